// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the SPI DAC transmitter.
//   tx_state_t    : transmitter FSM states
//   FRAME_W/DATA_W: serial frame and sample widths
//   CFG_*         : bit positions of the DAC configuration field in the frame
//   max3()        : helper used to size the shared phase counter
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    LDAC
  } tx_state_t;

  localparam int FRAME_W    = 16;
  localparam int DATA_W     = 12;

  localparam int CFG_AB     = 15;
  localparam int CFG_BUF    = 14;
  localparam int CFG_GA_B   = 13;
  localparam int CFG_SHDN_B = 12;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter with a terminal-count strobe.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load; a phase of N cycles loads N-1
//   tc         : high while the count is zero (last cycle of the phase)
module phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/spi_dac_tx.sv
// spi_dac_tx: shifts 12-bit samples to an MCP4921-class DAC as 16-bit SPI
// frames ({CONFIG, sample}, MSB first, mode 0), then pulses LDAC.
//   clk, reset    : clock, asynchronous active-high reset
//   sample_data   : sample, captured when sample_valid && sample_ready
//   sample_valid  : upstream has a sample
//   sample_ready  : high in IDLE
//   dac_cs_b      : chip select, active low
//   dac_sclk      : SPI clock, idle low
//   dac_din       : serial data
//   dac_ldac_b    : latch strobe, active low
//   busy          : high outside IDLE
module spi_dac_tx
  import dac_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter int         CS_SETUP = 2,
  parameter int         LDAC_W   = 2,
  parameter logic [3:0] CONFIG   = 4'b0011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              dac_cs_b,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              dac_ldac_b,
  output logic              busy
);

  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, LDAC_W)) + 1;
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_DIV   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_LDAC  = CNT_W'(LDAC_W - 1);

  tx_state_t          state_reg, state_next;
  logic [3:0]         bit_cnt_reg, bit_cnt_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic               sclk_reg, sclk_next;
  logic               cs_b_reg, cs_b_next;
  logic               ldac_b_reg, ldac_b_next;
  logic               din_reg, din_next;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_tc;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // State register; the pin drivers are registered alongside it so every
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 4'd0;
      frame_reg   <= '0;
      sclk_reg    <= 1'b0;
      cs_b_reg    <= 1'b1;
      ldac_b_reg  <= 1'b1;
      din_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      frame_reg   <= frame_next;
      sclk_reg    <= sclk_next;
      cs_b_reg    <= cs_b_next;
      ldac_b_reg  <= ldac_b_next;
      din_reg     <= din_next;
    end
  end

  // Next-state logic. The timer is reloaded on entry to each timed phase;
  // tc marks the final cycle of that phase.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    frame_next   = frame_reg;
    sclk_next    = sclk_reg;
    tmr_load     = 1'b0;
    tmr_val      = LD_DIV;
    case (state_reg)
      IDLE: begin
        sclk_next = 1'b0;
        if (sample_valid) begin
          state_next   = SETUP;
          frame_next   = {CONFIG, sample_data};
          bit_cnt_next = 4'd15;
          tmr_load     = 1'b1;
          tmr_val      = LD_SETUP;
        end
      end
      SETUP: begin
        if (tmr_tc) begin
          state_next = SHIFT;
          tmr_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else begin
            // End of a high phase: drop sclk and move to the next bit,
            // or to HOLD once bit 0 has been clocked.
            sclk_next = 1'b0;
            if (bit_cnt_reg == 4'd0) begin
              state_next = HOLD;
            end else begin
              bit_cnt_next = bit_cnt_reg - 4'd1;
              frame_next   = {frame_reg[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (tmr_tc) begin
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = LDAC;
        tmr_load   = 1'b1;
        tmr_val    = LD_LDAC;
      end
      LDAC: begin
        if (tmr_tc) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode, from the state being entered so the registered pins
  // line up with state_reg.
  always_comb begin
    cs_b_next   = !(state_next inside {SETUP, SHIFT, HOLD});
    ldac_b_next = (state_next != LDAC);
    din_next    = 1'b0;
    if (state_next == SETUP || state_next == SHIFT) begin
      din_next = frame_next[CFG_AB];
    end
  end

  assign dac_cs_b     = cs_b_reg;
  assign dac_sclk     = sclk_reg;
  assign dac_din      = din_reg;
  assign dac_ldac_b   = ldac_b_reg;
  assign sample_ready = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_dac_tx.sv
module tb_spi_dac_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample_data = 12'h000;
  logic [11:0] sample_data1 = 12'h000;
  logic        sample_valid = 1'b0;
  logic        sample_valid1 = 1'b0;

  logic sample_ready, dac_cs_b, dac_sclk, dac_din, dac_ldac_b, busy;
  logic sample_ready1, dac_cs_b1, dac_sclk1, dac_din1, dac_ldac_b1, busy1;

  always #5 clk = ~clk;

  spi_dac_tx u_dut (
    .clk          (clk),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_cs_b     (dac_cs_b),
    .dac_sclk     (dac_sclk),
    .dac_din      (dac_din),
    .dac_ldac_b   (dac_ldac_b),
    .busy         (busy)
  );

  spi_dac_tx #(.CLK_DIV(1), .CS_SETUP(1), .LDAC_W(1)) u_dut_min (
    .clk          (clk),
    .reset        (reset),
    .sample_data  (sample_data1),
    .sample_valid (sample_valid1),
    .sample_ready (sample_ready1),
    .dac_cs_b     (dac_cs_b1),
    .dac_sclk     (dac_sclk1),
    .dac_din      (dac_din1),
    .dac_ldac_b   (dac_ldac_b1),
    .busy         (busy1)
  );

  // sel picks which instance the shared tasks observe and drive.
  logic sel = 1'b0;
  logic m_ready, m_cs_b, m_sclk, m_din, m_ldac_b, m_busy;
  assign m_ready  = sel ? sample_ready1 : sample_ready;
  assign m_cs_b   = sel ? dac_cs_b1     : dac_cs_b;
  assign m_sclk   = sel ? dac_sclk1     : dac_sclk;
  assign m_din    = sel ? dac_din1      : dac_din;
  assign m_ldac_b = sel ? dac_ldac_b1   : dac_ldac_b;
  assign m_busy   = sel ? busy1         : busy;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_cs_b"},   32'(m_cs_b),   32'd1);
    check_val({tag, "_sclk"},   32'(m_sclk),   32'd0);
    check_val({tag, "_din"},    32'(m_din),    32'd0);
    check_val({tag, "_ldac_b"}, 32'(m_ldac_b), 32'd1);
    check_val({tag, "_busy"},   32'(m_busy),   32'd0);
    check_val({tag, "_ready"},  32'(m_ready),  32'd1);
  endtask

  // Called at a negedge with the selected DUT idle; returns 1 ns after the
  // accepting posedge.
  task automatic send(input string tag, input logic [11:0] d, input bit hold);
    if (sel) begin
      sample_data1  = d;
      sample_valid1 = 1'b1;
    end else begin
      sample_data   = d;
      sample_valid  = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      sample_valid  = 1'b0;
      sample_valid1 = 1'b0;
    end
    check_val({tag, "_accept"}, 32'(m_busy), 32'd1);
  endtask

  // Observes one frame at negedges, starting right after the accept edge,
  // until sample_ready returns. Cycle n observes the state entered on the
  // (n-1)-th edge after the accept edge.
  task automatic watch(output logic [15:0] fr, output int rises, output int cs_lo,
                       output int ld_lo, output int ld_gap, output int rdy,
                       output int first_rise, output int per_min, output int per_max);
    int n, cs_rise_at, ld_fall_at, last_rise;
    logic prev;
    n = 0; prev = 1'b0; cs_rise_at = -1; ld_fall_at = -1; last_rise = -1;
    fr = '0; rises = 0; cs_lo = 0; ld_lo = 0; first_rise = -1;
    per_min = 9999; per_max = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_sclk && !prev) begin
        rises++;
        fr = {fr[14:0], m_din};
        if (first_rise < 0) begin
          first_rise = n - 1;
        end else begin
          if (n - last_rise < per_min) per_min = n - last_rise;
          if (n - last_rise > per_max) per_max = n - last_rise;
        end
        last_rise = n;
      end
      prev = m_sclk;
      if (!m_cs_b) cs_lo++;
      else if (cs_rise_at < 0 && cs_lo > 0) cs_rise_at = n;
      if (!m_ldac_b) begin
        ld_lo++;
        if (ld_fall_at < 0) ld_fall_at = n;
      end
    end while (!m_ready && n < 2000);
    check_val("frame_done", 32'(m_ready), 32'd1);
    rdy    = n - 1;
    ld_gap = ld_fall_at - cs_rise_at;
  endtask

  logic [15:0] fr;
  int rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax;
  logic [11:0] stall_exp;

  initial begin
    // Reset check
    repeat (5) @(negedge clk);
    check_idle("rst_hold");
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst_rel");

    // Single frame at defaults
    send("single", 12'hABC, 1'b0);
    watch(fr, rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax);
    check_val("single_rises",      32'(rises),  32'd16);
    check_val("single_frame",      32'(fr),     32'h3ABC);
    check_val("single_cs_low",     32'(cs_lo),  32'd134);
    check_val("single_first_rise", 32'(fst),    32'd6);
    check_val("single_sclk_per",   32'(pmax),   32'd8);
    check_val("single_ldac_low",   32'(ld_lo),  32'd2);
    check_val("single_ldac_gap",   32'(ld_gap), 32'd1);
    check_val("single_ready",      32'(rdy),    32'd137);

    // Back-to-back with valid held high
    send("b2b0", 12'h000, 1'b1);
    sample_data = 12'hFFF;
    watch(fr, rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax);
    check_val("b2b0_frame", 32'(fr),  32'h3000);
    check_val("b2b0_ready", 32'(rdy), 32'd137);
    @(posedge clk);
    #1;
    check_val("b2b1_accept_first_idle", 32'(busy), 32'd1);
    sample_valid = 1'b0;
    watch(fr, rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax);
    check_val("b2b1_frame", 32'(fr), 32'h3FFF);

    // Stall: valid raised mid-frame with sample_data changing every cycle
    send("stall", 12'h111, 1'b0);
    fork
      watch(fr, rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax);
      begin
        int i;
        i = 0;
        repeat (10) @(negedge clk);
        sample_valid = 1'b1;
        while (i < 1000) begin
          sample_data = 12'h400 + 12'(i);
          @(negedge clk);
          if (sample_ready) break;
          i++;
        end
      end
    join
    check_val("stall_inflight_frame", 32'(fr),  32'h3111);
    check_val("stall_no_early_accept", 32'(rdy), 32'd137);
    stall_exp = sample_data;
    @(posedge clk);
    #1;
    check_val("stall_accept", 32'(busy), 32'd1);
    sample_valid = 1'b0;
    watch(fr, rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax);
    check_val("stall_frame", 32'(fr), 32'({4'h3, stall_exp}));

    // Reset during bit 7 (ninth sclk rise)
    send("midrst", 12'hFED, 1'b0);
    begin
      int r, k, ldl;
      logic prev;
      r = 0; k = 0; ldl = 0; prev = 1'b0;
      while (r < 9 && k < 500) begin
        @(negedge clk);
        k++;
        if (dac_sclk && !prev) r++;
        prev = dac_sclk;
      end
      check_val("midrst_reach_bit7", 32'(r), 32'd9);
      #2 reset = 1'b1;
      #1 check_idle("midrst_async");
      repeat (3) begin
        @(negedge clk);
        if (!dac_ldac_b) ldl++;
      end
      reset = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (!dac_ldac_b) ldl++;
      end
      check_val("midrst_no_ldac", 32'(ldl), 32'd0);
      check_idle("midrst_after");
    end
    send("post_rst", 12'h123, 1'b0);
    watch(fr, rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax);
    check_val("post_rst_frame", 32'(fr),    32'h3123);
    check_val("post_rst_rises", 32'(rises), 32'd16);
    check_val("post_rst_ready", 32'(rdy),   32'd137);

    // Minimum parameters: CLK_DIV = CS_SETUP = LDAC_W = 1
    sel = 1'b1;
    @(negedge clk);
    send("min", 12'h5A5, 1'b0);
    watch(fr, rises, cs_lo, ld_lo, ld_gap, rdy, fst, pmin, pmax);
    check_val("min_frame",      32'(fr),    32'h35A5);
    check_val("min_rises",      32'(rises), 32'd16);
    check_val("min_per_lo",     32'(pmin),  32'd2);
    check_val("min_per_hi",     32'(pmax),  32'd2);
    check_val("min_first_rise", 32'(fst),   32'd2);
    check_val("min_cs_low",     32'(cs_lo), 32'd34);
    check_val("min_ldac_low",   32'(ld_lo), 32'd1);
    // 1 setup + 33 shift/hold + 1 gap + 1 ldac
    check_val("min_ready",      32'(rdy),   32'd36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
